// File: rtl/ras_ctrl.sv
// ras_ctrl -- fetch-side driver of the return address stack.
//
// Pre-decodes each fetch group. It finds the first call (JAL, JALR rd=31,
// BLTZAL/BGEZAL) or return (JR $31) among the slots whose mask bit is set,
// and issues a push or a pop to the RAS. JAL and returns predicted from a
// valid RAS top raise a one-cycle fetch redirect. The redirect fires only
// after the branch delay slot has been fetched.
//
// Ports
//   clk, reset        clock; synchronous active-high reset
//   flush_i           abandons any pending redirect and suppresses push/pop
//   grp_valid_i       fetch group valid (always accepted)
//   grp_pc_i          PC of slot 0; slot i lives at grp_pc_i + 4*i
//   grp_instr_i       slot i = grp_instr_i[32*i +: 32]
//   grp_mask_i        per-slot valid
//   ras_push_req_o    push request (combinational)
//   ras_pop_req_o     pop request (combinational)
//   ras_push_data_o   return address = call slot PC + 8
//   ras_top_i         current RAS top, value before this cycle's update
//   redirect_valid_o  registered one-cycle redirect pulse
//   redirect_pc_o     registered redirect target
//   busy_o            a redirect is pending or being issued

package ras_pkg;
    typedef struct packed {
        logic [31:0] data;
        logic        valid;
    } ras_t;
endpackage

module ras_ctrl
    import ras_pkg::*;
#(
    parameter int FETCH_WIDTH = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush_i,
    input  logic                      grp_valid_i,
    input  logic [31:0]               grp_pc_i,
    input  logic [32*FETCH_WIDTH-1:0] grp_instr_i,
    input  logic [FETCH_WIDTH-1:0]    grp_mask_i,
    output logic                      ras_push_req_o,
    output logic                      ras_pop_req_o,
    output logic [31:0]               ras_push_data_o,
    input  ras_t                      ras_top_i,
    output logic                      redirect_valid_o,
    output logic [31:0]               redirect_pc_o,
    output logic                      busy_o
);

    localparam int SW = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_DS = 2'd1,
        REDIR   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] tgt_q, tgt_d;
    logic        redirect_valid_q, redirect_valid_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;

    // ------------------------------------------------------------------
    // Per-slot pre-decode
    // ------------------------------------------------------------------
    logic [FETCH_WIDTH-1:0] is_jal, is_call, is_ret;

    for (genvar g = 0; g < FETCH_WIDTH; g++) begin : g_dec
        logic [5:0] op, funct;
        logic [4:0] rs, rt, rd;
        assign op    = grp_instr_i[32*g+26 +: 6];
        assign rs    = grp_instr_i[32*g+21 +: 5];
        assign rt    = grp_instr_i[32*g+16 +: 5];
        assign rd    = grp_instr_i[32*g+11 +: 5];
        assign funct = grp_instr_i[32*g    +: 6];

        assign is_jal[g]  = (op == 6'b000011);
        // JALR with rd=31 is only ever a call, even when rs=31.
        assign is_call[g] = is_jal[g]
                          || (op == 6'b000000 && funct == 6'b001001 && rd == 5'd31)
                          || (op == 6'b000001 && (rt == 5'b10000 || rt == 5'b10001));
        assign is_ret[g]  = (op == 6'b000000 && funct == 6'b001000 && rs == 5'd31);
    end

    // ------------------------------------------------------------------
    // Lowest-index control-flow slot
    // ------------------------------------------------------------------
    logic          cf_found;
    logic [SW-1:0] cf_slot;

    always_comb begin
        cf_found = 1'b0;
        cf_slot  = '0;
        // Scan downward so the lowest qualifying index is the last one written.
        for (int i = FETCH_WIDTH - 1; i >= 0; i--) begin
            if (grp_mask_i[i] && (is_call[i] || is_ret[i])) begin
                cf_found = 1'b1;
                cf_slot  = SW'(i);
            end
        end
    end

    logic        cf_jal, cf_call, cf_ret;
    logic [25:0] cf_imm;
    logic [31:0] slot_pc, slot_pc_p4, jal_tgt, cf_tgt;
    logic        cf_targeted, accept;

    assign cf_jal      = is_jal[cf_slot];
    assign cf_call     = is_call[cf_slot];
    assign cf_ret      = is_ret[cf_slot];
    assign cf_imm      = grp_instr_i[32'(cf_slot)*32 +: 26];

    assign slot_pc     = grp_pc_i + (32'(cf_slot) << 2);
    assign slot_pc_p4  = slot_pc + 32'd4;
    assign jal_tgt     = {slot_pc_p4[31:28], cf_imm, 2'b00};
    assign cf_tgt      = cf_jal ? jal_tgt : ras_top_i.data;
    assign cf_targeted = cf_jal || (cf_ret && ras_top_i.valid);

    // Groups seen in WAIT_DS (delay slot) or REDIR (wrong path) never touch the RAS.
    assign accept = !reset && !flush_i && grp_valid_i && cf_found && (state_q == IDLE);

    assign ras_push_req_o  = accept && cf_call;
    assign ras_pop_req_o   = accept && cf_ret;
    assign ras_push_data_o = slot_pc_p4 + 32'd4;

    // ------------------------------------------------------------------
    // Redirect FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d          = state_q;
        tgt_d            = tgt_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;

        unique case (state_q)
            IDLE: begin
                if (accept && cf_targeted) begin
                    tgt_d = cf_tgt;
                    if (cf_slot == SW'(FETCH_WIDTH - 1)) begin
                        // Delay slot lands in the next group.
                        state_d = WAIT_DS;
                    end else begin
                        state_d          = REDIR;
                        redirect_valid_d = 1'b1;
                        redirect_pc_d    = cf_tgt;
                    end
                end
            end
            WAIT_DS: begin
                if (grp_valid_i) begin
                    state_d          = REDIR;
                    redirect_valid_d = 1'b1;
                    redirect_pc_d    = tgt_q;
                end
            end
            REDIR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (flush_i) begin
            state_d          = IDLE;
            redirect_valid_d = 1'b0;
            redirect_pc_d    = redirect_pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= IDLE;
            tgt_q            <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            state_q          <= state_d;
            tgt_q            <= tgt_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    assign redirect_valid_o = redirect_valid_q;
    assign redirect_pc_o    = redirect_pc_q;
    assign busy_o           = (state_q != IDLE);

endmodule
